// File: rtl/johnson_step_sequencer_if.sv
// Command channel for johnson_step_sequencer: valid/ready handshake plus step/load payload.
// The host drives the master side and the sequencer drives the slave side.
interface johnson_step_sequencer_if #(
  parameter int unsigned STEP_W = 8
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_load;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic [3:0]        cmd_value;

  modport master (
    output cmd_valid,
    output cmd_load,
    output cmd_dir,
    output cmd_steps,
    output cmd_value,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_load,
    input  cmd_dir,
    input  cmd_steps,
    input  cmd_value,
    output cmd_ready
  );
endinterface

// File: rtl/johnson_step_sequencer.sv
// Command-driven stepper for a 4-bit Johnson counter, one step per PRESCALE clocks.
// Define JOHNSON_SEQ_CHECK_EN to reject illegal load codes and raise a sticky err.
module johnson_step_sequencer #(
  parameter int unsigned STEP_W   = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  johnson_step_sequencer_if.slave io_cmd,
  input  logic                    i_abort,
  output logic [3:0]              o_cnt,
  output logic [2:0]              o_pos,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  localparam int unsigned PresW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PresW-1:0] PresLast = PresW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StLoad,
    StDone
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        r_value;
  logic              r_dir;
  logic [STEP_W-1:0] r_rem;
  logic [PresW-1:0]  r_pres;
  logic              r_busy;
  logic              r_done;
  logic              w_tick;
  logic              w_last;
  logic              w_load_ok;
  logic [3:0]        w_cnt_up;
  logic [3:0]        w_cnt_dn;

  assign w_cnt_up = {r_cnt[2:0], ~r_cnt[3]};
  assign w_cnt_dn = {~r_cnt[0], r_cnt[3:1]};
  assign w_tick   = (r_pres == PresLast);
  assign w_last   = w_tick && (r_rem == STEP_W'(1));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (io_cmd.cmd_valid) begin
          if (io_cmd.cmd_load) begin
            w_state_nxt = StLoad;
          end else if (io_cmd.cmd_steps == '0) begin
            w_state_nxt = StDone;
          end else begin
            w_state_nxt = StRun;
          end
        end
      end
      // Abort wins over a step that falls due on the same edge.
      StRun: begin
        if (i_abort || w_last) begin
          w_state_nxt = StDone;
        end
      end
      StLoad:  w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    io_cmd.cmd_ready = (r_state == StIdle);
    o_pos = 3'd0;
    case (r_cnt)
      4'b0000: o_pos = 3'd0;
      4'b0001: o_pos = 3'd1;
      4'b0011: o_pos = 3'd2;
      4'b0111: o_pos = 3'd3;
      4'b1111: o_pos = 3'd4;
      4'b1110: o_pos = 3'd5;
      4'b1100: o_pos = 3'd6;
      4'b1000: o_pos = 3'd7;
      default: o_pos = 3'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cnt   <= 4'b0000;
      r_value <= 4'b0000;
      r_dir   <= 1'b0;
      r_rem   <= '0;
      r_pres  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == StRun);
      r_done <= (w_state_nxt == StDone);
      case (r_state)
        StIdle: begin
          if (io_cmd.cmd_valid) begin
            r_dir   <= io_cmd.cmd_dir;
            r_rem   <= io_cmd.cmd_steps;
            r_value <= io_cmd.cmd_value;
            r_pres  <= '0;
          end
        end
        StRun: begin
          if (!i_abort) begin
            if (w_tick) begin
              r_pres <= '0;
              r_rem  <= r_rem - 1'b1;
              r_cnt  <= r_dir ? w_cnt_dn : w_cnt_up;
            end else begin
              r_pres <= r_pres + 1'b1;
            end
          end
        end
        StLoad: begin
          if (w_load_ok) begin
            r_cnt <= r_value;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef JOHNSON_SEQ_CHECK_EN
  logic r_err;
  logic w_legal;

  always_comb begin
    w_legal = 1'b0;
    case (r_value)
      4'b0000, 4'b0001, 4'b0011, 4'b0111,
      4'b1111, 4'b1110, 4'b1100, 4'b1000: w_legal = 1'b1;
      default:                            w_legal = 1'b0;
    endcase
  end

  assign w_load_ok = w_legal;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_err <= 1'b0;
    end else if ((r_state == StLoad) && !w_legal) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign w_load_ok = 1'b1;
  assign o_err     = 1'b0;
`endif

  assign o_cnt  = r_cnt;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_johnson_step_sequencer.sv
// Scoreboard bench for johnson_step_sequencer: two instances (PRESCALE 1 and 3), directed
// commands push hand-computed cnt changes and done pulses; a negedge monitor pops and compares.
module tb_johnson_step_sequencer;

  localparam int unsigned STEP_W = 8;

  typedef struct {
    int         sel;
    bit         is_done;
    logic [3:0] cnt;
    logic [2:0] pos;
    logic       err;
    int         ofs;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       abort    [2];
  logic [3:0] cnt      [2];
  logic [2:0] pos      [2];
  logic       busy     [2];
  logic       done     [2];
  logic       err      [2];
  logic [3:0] prev_cnt [2];
  int         cyc = 0;
  int         e0  [2];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         bc;
  exp_t       exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  johnson_step_sequencer_if #(.STEP_W(STEP_W)) bus0 ();
  johnson_step_sequencer_if #(.STEP_W(STEP_W)) bus1 ();

  johnson_step_sequencer #(.STEP_W(STEP_W), .PRESCALE(1)) u_dut0 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_cmd (bus0),
    .i_abort(abort[0]),
    .o_cnt  (cnt[0]),
    .o_pos  (pos[0]),
    .o_busy (busy[0]),
    .o_done (done[0]),
    .o_err  (err[0])
  );

  johnson_step_sequencer #(.STEP_W(STEP_W), .PRESCALE(3)) u_dut1 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_cmd (bus1),
    .i_abort(abort[1]),
    .o_cnt  (cnt[1]),
    .o_pos  (pos[1]),
    .o_busy (busy[1]),
    .o_done (done[1]),
    .o_err  (err[1])
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic drv_edge();
    @(negedge clk);
    #1;
  endtask

  function automatic logic rdy(input int s);
    return (s == 0) ? bus0.cmd_ready : bus1.cmd_ready;
  endfunction

  task automatic set_cmd(input int s, input bit v, input bit ld, input bit dir, input int n,
                         input logic [3:0] val);
    if (s == 0) begin
      bus0.cmd_valid = v; bus0.cmd_load = ld; bus0.cmd_dir = dir;
      bus0.cmd_steps = STEP_W'(n); bus0.cmd_value = val;
    end else begin
      bus1.cmd_valid = v; bus1.cmd_load = ld; bus1.cmd_dir = dir;
      bus1.cmd_steps = STEP_W'(n); bus1.cmd_value = val;
    end
  endtask

  task automatic set_valid(input int s, input bit v);
    if (s == 0) bus0.cmd_valid = v;
    else        bus1.cmd_valid = v;
  endtask

  task automatic exp_step(input int s, input logic [3:0] c, input logic [2:0] p, input int ofs,
                          input string tag);
    exp_q.push_back('{sel: s, is_done: 1'b0, cnt: c, pos: p, err: 1'b0, ofs: ofs, tag: tag});
  endtask

  task automatic exp_done(input int s, input logic [3:0] c, input logic [2:0] p, input logic e,
                          input int ofs, input string tag);
    exp_q.push_back('{sel: s, is_done: 1'b1, cnt: c, pos: p, err: e, ofs: ofs, tag: tag});
  endtask

  // Offsets are counted in rising edges from the accepting edge.
  task automatic issue(input int s, input bit ld, input bit dir, input int n,
                       input logic [3:0] val, input bit hold);
    chk($sformatf("dut%0d_ready_before_cmd", s), rdy(s), 1);
    e0[s] = cyc + 1;
    set_cmd(s, 1'b1, ld, dir, n, val);
    drv_edge();
    if (!hold) set_valid(s, 1'b0);
  endtask

  task automatic wait_idle(input int s, input bit drop_on_done, output int busy_cycles);
    busy_cycles = 0;
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0 && rdy(s) == 1'b1) return;
      if (busy[s] === 1'b1) begin
        busy_cycles++;
        chk($sformatf("dut%0d_ready_low_in_run", s), rdy(s), 0);
      end
      if (drop_on_done && done[s] === 1'b1) set_valid(s, 1'b0);
      drv_edge();
    end
    n_tests++;
    n_fail++;
    $display("FAIL dut%0d_timeout: got %0d pending events, expected 0", s, exp_q.size());
    exp_q.delete();
  endtask

  task automatic check_evt(input int s, input bit is_done);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL dut%0d_unexpected_event: got done=%0b cnt=%b, expected no event",
               s, is_done, cnt[s]);
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("%s_sel", e.tag), s, e.sel);
    chk($sformatf("%s_kind", e.tag), is_done, e.is_done);
    chk($sformatf("%s_cnt", e.tag), cnt[s], e.cnt);
    chk($sformatf("%s_pos", e.tag), pos[s], e.pos);
    chk($sformatf("%s_ofs", e.tag), cyc - e0[s], e.ofs);
    if (is_done) chk($sformatf("%s_err", e.tag), err[s], e.err);
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rst === 1'b1) begin
        if (cnt[s] !== prev_cnt[s]) check_evt(s, 1'b0);
        if (done[s] !== 1'b0) check_evt(s, 1'b1);
      end
      prev_cnt[s] = cnt[s];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    abort[0] = 1'b0;
    abort[1] = 1'b0;
    set_cmd(0, 1'b0, 1'b0, 1'b0, 0, 4'b0000);
    set_cmd(1, 1'b0, 1'b0, 1'b0, 0, 4'b0000);
    rst = 1'b0;
    repeat (3) drv_edge();
    chk("rst_cnt", cnt[0], 4'b0000);
    chk("rst_pos", pos[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_err", err[0], 0);
    chk("rst_ready", rdy(0), 1);
    chk("rst_cnt_p3", cnt[1], 4'b0000);
    chk("rst_ready_p3", rdy(1), 1);
    rst = 1'b1;
    drv_edge();

    // Up 3 steps from 0000.
    exp_step(0, 4'b0001, 3'd1, 1, "up3_s1");
    exp_step(0, 4'b0011, 3'd2, 2, "up3_s2");
    exp_step(0, 4'b0111, 3'd3, 3, "up3_s3");
    exp_done(0, 4'b0111, 3'd3, 1'b0, 3, "up3_done");
    issue(0, 1'b0, 1'b0, 3, 4'b0000, 1'b0);
    wait_idle(0, 1'b0, bc);
    chk("up3_busy_cycles", bc, 3);

    // Zero steps: done right after accept, cnt held.
    exp_done(0, 4'b0111, 3'd3, 1'b0, 0, "zero_done");
    issue(0, 1'b0, 1'b1, 0, 4'b0000, 1'b0);
    wait_idle(0, 1'b0, bc);
    chk("zero_busy_cycles", bc, 0);

    // Reset mid-run: two steps land, then everything is abandoned.
    exp_step(0, 4'b1111, 3'd4, 1, "rstrun_s1");
    exp_step(0, 4'b1110, 3'd5, 2, "rstrun_s2");
    issue(0, 1'b0, 1'b0, 5, 4'b0000, 1'b0);
    for (int k = 0; k < 10 && (cyc - e0[0]) < 2; k++) drv_edge();
    rst = 1'b0;
    exp_q.delete();
    drv_edge();
    drv_edge();
    chk("rstrun_cnt", cnt[0], 4'b0000);
    chk("rstrun_done", done[0], 0);
    chk("rstrun_busy", busy[0], 0);
    chk("rstrun_ready", rdy(0), 1);
    rst = 1'b1;
    drv_edge();

    // Down 9 steps from 0000 wraps through the whole ring.
    exp_step(0, 4'b1000, 3'd7, 1, "dn9_s1");
    exp_step(0, 4'b1100, 3'd6, 2, "dn9_s2");
    exp_step(0, 4'b1110, 3'd5, 3, "dn9_s3");
    exp_step(0, 4'b1111, 3'd4, 4, "dn9_s4");
    exp_step(0, 4'b0111, 3'd3, 5, "dn9_s5");
    exp_step(0, 4'b0011, 3'd2, 6, "dn9_s6");
    exp_step(0, 4'b0001, 3'd1, 7, "dn9_s7");
    exp_step(0, 4'b0000, 3'd0, 8, "dn9_s8");
    exp_step(0, 4'b1000, 3'd7, 9, "dn9_s9");
    exp_done(0, 4'b1000, 3'd7, 1'b0, 9, "dn9_done");
    issue(0, 1'b0, 1'b1, 9, 4'b0000, 1'b0);
    wait_idle(0, 1'b0, bc);

    // Load a legal code; load takes priority over the step fields.
    exp_step(0, 4'b1110, 3'd5, 1, "ld1110");
    exp_done(0, 4'b1110, 3'd5, 1'b0, 1, "ld1110_done");
    issue(0, 1'b1, 1'b1, 3, 4'b1110, 1'b0);
    wait_idle(0, 1'b0, bc);

    // Illegal load, then one up step.
`ifdef JOHNSON_SEQ_CHECK_EN
    exp_done(0, 4'b1110, 3'd5, 1'b1, 1, "ld0101_done");
    issue(0, 1'b1, 1'b0, 0, 4'b0101, 1'b0);
    wait_idle(0, 1'b0, bc);
    exp_step(0, 4'b1100, 3'd6, 1, "after_ld_s1");
    exp_done(0, 4'b1100, 3'd6, 1'b1, 1, "after_ld_done");
`else
    exp_step(0, 4'b0101, 3'd0, 1, "ld0101");
    exp_done(0, 4'b0101, 3'd0, 1'b0, 1, "ld0101_done");
    issue(0, 1'b1, 1'b0, 0, 4'b0101, 1'b0);
    wait_idle(0, 1'b0, bc);
    exp_step(0, 4'b1011, 3'd0, 1, "after_ld_s1");
    exp_done(0, 4'b1011, 3'd0, 1'b0, 1, "after_ld_done");
`endif
    issue(0, 1'b0, 1'b0, 1, 4'b0000, 1'b0);
    wait_idle(0, 1'b0, bc);

    // PRESCALE=3, up 2 with cmd_valid held through RUN.
    exp_step(1, 4'b0001, 3'd1, 3, "p3_s1");
    exp_step(1, 4'b0011, 3'd2, 6, "p3_s2");
    exp_done(1, 4'b0011, 3'd2, 1'b0, 6, "p3_done");
    issue(1, 1'b0, 1'b0, 2, 4'b0000, 1'b1);
    wait_idle(1, 1'b1, bc);
    chk("p3_busy_cycles", bc, 6);
    set_valid(1, 1'b0);
    repeat (4) drv_edge();
    chk("p3_idle_busy", busy[1], 0);
    chk("p3_idle_cnt", cnt[1], 4'b0011);

    // Abort on the edge the second step is due.
    exp_step(1, 4'b0111, 3'd3, 3, "abort_s1");
    exp_done(1, 4'b0111, 3'd3, 1'b0, 6, "abort_done");
    issue(1, 1'b0, 1'b0, 4, 4'b0000, 1'b0);
    for (int k = 0; k < 20 && (cyc - e0[1]) < 5; k++) drv_edge();
    abort[1] = 1'b1;
    drv_edge();
    abort[1] = 1'b0;
    wait_idle(1, 1'b0, bc);

    // Abort while idle is ignored.
    abort[1] = 1'b1;
    repeat (3) drv_edge();
    abort[1] = 1'b0;
    chk("abort_idle_cnt", cnt[1], 4'b0111);
    chk("abort_idle_ready", rdy(1), 1);

    drv_edge();
    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/johnson_step_sequencer.md
# johnson_step_sequencer

Command-driven controller for the 4-bit Johnson counter datapath. It accepts step or load commands over a valid/ready handshake and advances the counter up or down by a requested number of steps, at one step per PRESCALE clocks. It reports busy status, a one-cycle completion pulse and the decoded ring position. It sits between a host/control FSM and any logic that consumes the Johnson code.

## Interface
Parameters:
- STEP_W, 8, width of the step-count field
- PRESCALE, 1, clocks per counter step (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command (high only in IDLE)
- cmd_load  in  1  1 = load cmd_value; 0 = step command
- cmd_dir  in  1  step direction, 1 = down, 0 = up
- cmd_steps  in  STEP_W  number of steps; 0 = no-op
- cmd_value  in  4  load value
- abort  in  1  terminate a running step command
- cnt  out  4  Johnson counter state
- pos  out  3  decoded position 0-7
- busy  out  1  high in RUN
- done  out  1  one-cycle completion pulse
- err  out  1  sticky illegal-load flag

## Operation
- Johnson ring positions 0-7: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000.
  - pos is the combinational decode of cnt.
  - An illegal cnt decodes to pos=0.
- Step up: cnt ← {cnt[2:0], ~cnt[3]}. Step down: cnt ← {~cnt[0], cnt[3:1]}.
  - Both wrap naturally: 1000 up → 0000; 0000 down → 1000.
- FSM states: IDLE, RUN, LOAD, DONE.
- IDLE
  - cmd_ready=1.
  - On cmd_valid at an edge, latch cmd_dir and cmd_steps.
  - If cmd_load=1 → LOAD.
  - Else if cmd_steps=0 → DONE.
  - Else → RUN: remaining=cmd_steps, prescale counter=0.
- RUN
  - busy=1. Prescale counter counts 0..PRESCALE-1.
  - On the edge where it wraps: step cnt in the latched direction and decrement remaining.
  - When remaining reaches 0 on that edge → DONE.
- abort
  - Sampled high in RUN: → DONE at that edge; no step on that edge, even if a step was due. abort has priority.
  - abort in IDLE, LOAD or DONE is ignored.
- LOAD: writes cnt (see Configuration) at the edge leaving LOAD → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- cmd_valid outside IDLE is ignored. The command is not queued.
- remaining is STEP_W bits; cmd_steps = 2^STEP_W-1 is the maximum run.

## Timing
- Reset values (after a clock edge with rst=0): state=IDLE, cnt=0000, pos=0, busy=0, done=0, err=0, cmd_ready=1.
  - Commands are not accepted while rst=0.
- Reset mid-RUN/LOAD/DONE abandons the command: cnt=0000 and no done pulse.
- Accept at edge E0 with N>0 steps:
  - Steps occur at edges E0+k·PRESCALE, k=1..N.
  - done is high in the cycle following E0+N·PRESCALE.
  - cmd_ready returns high one edge later.
- Zero-step command: done high in the cycle after E0; cnt unchanged.
- Load: cnt updated at E0+1; done high in the cycle after E0+1.
- Back-to-back: the next command can be accepted at the first edge after done is high. Minimum command spacing is N·PRESCALE+2 edges.
- cnt, busy, done, err are registered. pos and cmd_ready are state decodes.

## Configuration
- Macro JOHNSON_SEQ_CHECK_EN.
- Defined:
  - LOAD checks cmd_value against the 8 legal codes.
  - An illegal value leaves cnt unchanged and sets err; err stays high until reset.
  - done still pulses.
- Undefined:
  - cmd_value is loaded verbatim.
  - Later steps follow the shift rules within the illegal orbit.
  - err is tied 0.

## Test plan
- Reset, then an up step command with N=3, PRESCALE=1 → cnt 0001, 0011, 0111 on three consecutive edges; busy high for 3 cycles; done pulse one cycle later.
- From 0000, a down step command with N=9 → cnt sequence 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000, 1000; pos ends at 7.
- PRESCALE=3, up step command with N=2 → steps exactly 3 and 6 edges after accept; cmd_valid held during RUN is not re-accepted.
- Abort asserted in RUN on the edge a step is due → no step; done in the next cycle; cnt holds its last value.
- cmd_steps=0 → done in the cycle after accept; cnt unchanged. Reset asserted mid-RUN → cnt=0000; no done pulse.
- Load 0101:
  - With JOHNSON_SEQ_CHECK_EN → cnt unchanged, err=1 until reset.
  - Without it → cnt=0101, pos=0, err=0.
  - Load 1110 → pos=5 in both builds.
